stack_controller: RTL and testbench
===================================

// Module: stack_controller
// PURPOSE
//  Sequences all stack traffic for the 16-bit core: owns the stack pointer and turns push/pop/peek/load-SP
//  requests from the control unit into single-port data-memory accesses with a ready/ack handshake.
//  Sits between the control unit and the data-memory arbiter, replacing direct SP writes by the decoder.
//  Flags overflow/underflow instead of corrupting memory.
// PARAMETERS
//  SP_RESET     16'hFFFF  SP value after reset (empty stack, empty-descending convention)
//  STACK_LIMIT  16'hFF00  lowest address a push may write; push at SP==STACK_LIMIT is overflow
// PORTS
//  clk            in   1   clock, all state on posedge
//  reset          in   1   asynchronous, active-high
//  req_valid      in   1   request present
//  req_op         in   2   00 PUSH, 01 POP, 10 PEEK, 11 LOAD_SP
//  req_data       in   16  push data or new SP (LOAD_SP)
//  req_ready      out  1   controller can accept a request
//  rsp_valid      out  1   one-cycle pulse, one per accepted request
//  rsp_data       out  16  popped/peeked word; SP after op for PUSH/LOAD_SP
//  rsp_err        out  1   qualifies rsp_valid: op rejected (overflow/underflow)
//  mem_req        out  1   memory access request, held until mem_ack
//  mem_we         out  1   1 write, 0 read; stable while mem_req
//  mem_addr       out  16  stable while mem_req
//  mem_wdata      out  16  stable while mem_req
//  mem_ack        in   1   memory completes access on this edge; mem_rdata valid with it
//  mem_rdata      in   16  read data
//  sp             out  16  current stack pointer
//  err_overflow   out  1   sticky, cleared only by reset
//  err_underflow  out  1   sticky, cleared only by reset
// BEHAVIOUR
//  - Reset (async): state IDLE, sp=SP_RESET, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0,
//    mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, both sticky errors 0. Reset mid-access drops the
//    access silently (no rsp); memory side must tolerate an abandoned request.
//  - FSM states: IDLE, MEM, RESP. req_ready=1 only in IDLE. Accept = req_valid & req_ready at posedge.
//  - PUSH: if sp==STACK_LIMIT -> RESP with rsp_err=1, err_overflow<=1, sp unchanged, no mem access.
//    Else -> MEM: mem_we=1, mem_addr=sp, mem_wdata=req_data; on mem_ack sp<=sp-1, -> RESP,
//    rsp_data=new sp.
//  - POP: if sp==SP_RESET -> RESP, rsp_err=1, err_underflow<=1, sp unchanged. Else -> MEM: mem_we=0,
//    mem_addr=sp+1; on mem_ack capture mem_rdata into rsp_data, sp<=sp+1, -> RESP.
//  - PEEK: as POP (same underflow check) but sp never changes.
//  - LOAD_SP: no mem access; sp<=req_data at accept, -> RESP, rsp_data=req_data, rsp_err=0.
//  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_data/rsp_err hold until next rsp.
//  - Latency accept->rsp_valid: 1 cycle for error/LOAD_SP; N+1 cycles for memory ops where N = cycles
//    until mem_ack (mem_ack ignored outside MEM; earliest ack is the cycle after mem_req rises).
//  - sp updates only on mem_ack edge (PUSH/POP) or accept edge (LOAD_SP); never speculatively.
//  - Address arithmetic modulo 2^16; sp+1 at 16'hFFFF cannot occur (underflow check precedes it).
//  - req_op/req_data sampled only at accept; changes while busy are ignored.
//  - Back-to-back: new request accepted in IDLE cycle after RESP; minimum 2-cycle op spacing.
// TESTING
//  1 reset, PUSH 16'hA5A5 with ack after 1 cycle -> mem write @FFFF, sp=FFFE, rsp_data=FFFE, rsp_err=0
//  2 PUSH 1111,2222 then POP,POP -> rsp_data 2222 then 1111, reads @FFFE,@FFFF, final sp=FFFF
//  3 POP on empty (sp=FFFF) -> rsp_err=1 one cycle after accept, err_underflow=1, no mem_req, sp=FFFF
//  4 LOAD_SP FF00 then PUSH 0001 -> rsp_err=1, err_overflow=1, sp stays FF00, no mem_req
//  5 PEEK after PUSH BEEF -> rsp_data BEEF, sp unchanged; mem_ack delayed 5 cycles -> mem_* stable,
//    req_ready=0 throughout
//  6 assert reset while mem_req=1 -> immediately sp=FFFF, mem_req=0, no rsp_valid; next PUSH works

Source files
------------

// File: rtl/stack_controller.sv
// -----------------------------------------------------------------------------
// stack_controller
//
// Owns the stack pointer of the 16-bit core and converts push / pop / peek /
// load-SP requests from the control unit into single-port data-memory accesses.
// The stack is empty-descending: SP addresses the next free slot, so a push
// writes at SP and then decrements, and a pop reads at SP+1 and then increments.
// Overflow and underflow are reported and made sticky instead of touching memory.
//
// Ports
//   clk              clock, all state on the rising edge
//   reset            asynchronous, active-high
//   req_valid_i      request present
//   req_op_i  [1:0]  00 PUSH, 01 POP, 10 PEEK, 11 LOAD_SP
//   req_data_i[15:0] push data, or new SP for LOAD_SP
//   req_ready_o      high only while idle; accept = req_valid_i & req_ready_o
//   rsp_valid_o      one-cycle pulse per accepted request
//   rsp_data_o[15:0] popped/peeked word, or SP after the op for PUSH/LOAD_SP
//   rsp_err_o        qualifies rsp_valid_o: request rejected
//   mem_req_o        memory request, held until mem_ack_i
//   mem_we_o         1 write, 0 read
//   mem_addr_o[15:0] access address
//   mem_wdata_o[15:0] write data
//   mem_ack_i        memory completes the access on this edge
//   mem_rdata_i[15:0] read data, valid with mem_ack_i
//   sp_o      [15:0] current stack pointer
//   err_overflow_o   sticky push-overflow flag
//   err_underflow_o  sticky pop/peek-underflow flag
// -----------------------------------------------------------------------------
module stack_controller #(
    parameter logic [15:0] SP_RESET    = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    input  logic [1:0]  req_op_i,
    input  logic [15:0] req_data_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i,
    output logic [15:0] sp_o,
    output logic        err_overflow_o,
    output logic        err_underflow_o
);

    localparam logic [1:0] OP_PUSH    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PEEK    = 2'b10;
    localparam logic [1:0] OP_LOAD_SP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MEM  = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t      state_q,     state_d;
    logic [1:0]  op_q,        op_d;
    logic [15:0] sp_q,        sp_d;
    logic [15:0] rsp_data_q,  rsp_data_d;
    logic        rsp_err_q,   rsp_err_d;
    logic        mem_we_q,    mem_we_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        err_ovf_q,   err_ovf_d;
    logic        err_udf_q,   err_udf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_PUSH;
            sp_q        <= SP_RESET;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sp_q        <= sp_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_ovf_q   <= err_ovf_d;
            err_udf_q   <= err_udf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sp_d        = sp_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_ovf_d   = err_ovf_q;
        err_udf_d   = err_udf_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d = req_op_i;
                    case (req_op_i)
                        OP_PUSH: begin
                            if (sp_q == STACK_LIMIT) begin
                                // Rejected: report, but leave memory and SP untouched.
                                state_d    = S_RESP;
                                rsp_err_d  = 1'b1;
                                rsp_data_d = sp_q;
                                err_ovf_d  = 1'b1;
                            end else begin
                                state_d     = S_MEM;
                                mem_we_d    = 1'b1;
                                mem_addr_d  = sp_q;
                                mem_wdata_d = req_data_i;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            // Underflow check comes first, so sp_q+1 never wraps.
                            if (sp_q == SP_RESET) begin
                                state_d    = S_RESP;
                                rsp_err_d  = 1'b1;
                                rsp_data_d = sp_q;
                                err_udf_d  = 1'b1;
                            end else begin
                                state_d    = S_MEM;
                                mem_we_d   = 1'b0;
                                mem_addr_d = sp_q + 16'd1;
                            end
                        end
                        default: begin
                            // LOAD_SP takes effect on the accept edge.
                            state_d    = S_RESP;
                            sp_d       = req_data_i;
                            rsp_data_d = req_data_i;
                            rsp_err_d  = 1'b0;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    state_d   = S_RESP;
                    rsp_err_d = 1'b0;
                    case (op_q)
                        OP_PUSH: begin
                            sp_d       = sp_q - 16'd1;
                            rsp_data_d = sp_q - 16'd1;
                        end
                        OP_POP: begin
                            sp_d       = sp_q + 16'd1;
                            rsp_data_d = mem_rdata_i;
                        end
                        default: begin
                            rsp_data_d = mem_rdata_i;
                        end
                    endcase
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign rsp_valid_o     = (state_q == S_RESP);
    assign mem_req_o       = (state_q == S_MEM);
    assign rsp_data_o      = rsp_data_q;
    assign rsp_err_o       = rsp_err_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign sp_o            = sp_q;
    assign err_overflow_o  = err_ovf_q;
    assign err_underflow_o = err_udf_q;

endmodule

// File: tb/tb_stack_controller.sv
// -----------------------------------------------------------------------------
// tb_stack_controller
//
// Directed bench for stack_controller. A driver task issues one request, plays
// the memory side with a configurable ack delay, and reports what it saw; each
// test task compares those observations against hand-computed values.
// -----------------------------------------------------------------------------
module tb_stack_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [1:0]  req_op_i = 2'b00;
    logic [15:0] req_data_i = 16'h0000;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [15:0] rsp_data_o;
    logic        rsp_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [15:0] mem_rdata_i = 16'h0000;
    logic [15:0] sp_o;
    logic        err_overflow_o;
    logic        err_underflow_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] mem_model [logic [15:0]];

    // Results of the most recent do_op call
    logic [15:0] r_data;
    logic        r_err;
    int          r_lat;
    bit          r_saw_mem;
    logic [15:0] r_addr;
    logic        r_we;
    logic [15:0] r_wdata;
    bit          r_stable;
    bit          r_ready_low;

    always #5 clk = ~clk;

    stack_controller dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_op_i       (req_op_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_err_o      (rsp_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .sp_o           (sp_o),
        .err_overflow_o (err_overflow_o),
        .err_underflow_o(err_underflow_o)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ack_i = 1'b0;
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_model.delete();
    endtask

    // Issue one request from IDLE, respond to memory after ack_dly cycles of
    // mem_req, and return what was observed. Latency counts clock cycles from
    // the accept edge to the first cycle with rsp_valid high (-1 on timeout).
    task automatic do_op(input logic [1:0] op, input logic [15:0] data, input int ack_dly);
        int mem_cnt;
        r_lat = -1; r_saw_mem = 0; r_stable = 1; r_ready_low = 1;
        r_addr = 16'h0; r_we = 1'b0; r_wdata = 16'h0; r_data = 16'h0; r_err = 1'b0;
        mem_cnt = 0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i = op;
        req_data_i = data;
        @(posedge clk);
        #1;
        // Scramble the request lines: they must not be looked at while busy.
        req_valid_i = 1'b0;
        req_op_i = ~op;
        req_data_i = ~data;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (rsp_valid_o) begin
                r_lat = cyc;
                r_data = rsp_data_o;
                r_err = rsp_err_o;
                break;
            end
            if (req_ready_o) r_ready_low = 0;
            if (mem_req_o) begin
                if (!r_saw_mem) begin
                    r_saw_mem = 1; r_addr = mem_addr_o; r_we = mem_we_o; r_wdata = mem_wdata_o;
                end else if (mem_addr_o !== r_addr || mem_we_o !== r_we || (r_we && mem_wdata_o !== r_wdata)) begin
                    r_stable = 0;
                end
                mem_cnt++;
                if (mem_cnt == ack_dly) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) begin
                        mem_model[mem_addr_o] = mem_wdata_o;
                        mem_rdata_i = 16'hDEAD;
                    end else begin
                        mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 16'h0000;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++; if (sp_o !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_sp got %h want FFFF", sp_o); end
        tests_run++; if (req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
        tests_run++; if ({rsp_valid_o, rsp_err_o, mem_req_o, mem_we_o, err_overflow_o, err_underflow_o} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_flags got %b want 000000", {rsp_valid_o, rsp_err_o, mem_req_o, mem_we_o, err_overflow_o, err_underflow_o}); end
        tests_run++; if ({rsp_data_o, mem_addr_o, mem_wdata_o} !== 48'h0) begin
            tests_failed++; $display("FAIL reset_data got %h want 0", {rsp_data_o, mem_addr_o, mem_wdata_o}); end
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset: sp=%h ready=%b", sp_o, req_ready_o);
    endtask

    task automatic test_push();
        apply_reset();
        do_op(2'b00, 16'hA5A5, 1);
        $display("[TB] PUSH A5A5: lat=%0d addr=%h we=%b wdata=%h rsp=%h err=%b sp=%h", r_lat, r_addr, r_we, r_wdata, r_data, r_err, sp_o);
        tests_run++; if (!r_saw_mem || r_we !== 1'b1 || r_addr !== 16'hFFFF || r_wdata !== 16'hA5A5) begin
            tests_failed++; $display("FAIL push_mem got req=%0d we=%b addr=%h wdata=%h want 1/1/FFFF/A5A5", r_saw_mem, r_we, r_addr, r_wdata); end
        tests_run++; if (r_lat !== 2) begin tests_failed++; $display("FAIL push_latency got %0d want 2", r_lat); end
        tests_run++; if (r_data !== 16'hFFFE || r_err !== 1'b0) begin tests_failed++; $display("FAIL push_rsp got %h/%b want FFFE/0", r_data, r_err); end
        tests_run++; if (sp_o !== 16'hFFFE) begin tests_failed++; $display("FAIL push_sp got %h want FFFE", sp_o); end
        @(negedge clk);
        tests_run++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            tests_failed++; $display("FAIL push_pulse got valid=%b ready=%b want 0/1", rsp_valid_o, req_ready_o); end
    endtask

    task automatic test_push_pop();
        apply_reset();
        do_op(2'b00, 16'h1111, 1);
        do_op(2'b00, 16'h2222, 2);
        $display("[TB] PUSH 1111,2222: sp=%h", sp_o);
        tests_run++; if (sp_o !== 16'hFFFD) begin tests_failed++; $display("FAIL pp_sp_after_push got %h want FFFD", sp_o); end
        do_op(2'b01, 16'h0000, 1);
        $display("[TB] POP: addr=%h rsp=%h sp=%h", r_addr, r_data, sp_o);
        tests_run++; if (r_we !== 1'b0 || r_addr !== 16'hFFFE || r_data !== 16'h2222 || r_err !== 1'b0) begin
            tests_failed++; $display("FAIL pop1 got we=%b addr=%h data=%h err=%b want 0/FFFE/2222/0", r_we, r_addr, r_data, r_err); end
        do_op(2'b01, 16'h0000, 3);
        $display("[TB] POP: addr=%h rsp=%h sp=%h lat=%0d", r_addr, r_data, sp_o, r_lat);
        tests_run++; if (r_addr !== 16'hFFFF || r_data !== 16'h1111) begin
            tests_failed++; $display("FAIL pop2 got addr=%h data=%h want FFFF/1111", r_addr, r_data); end
        tests_run++; if (r_lat !== 4) begin tests_failed++; $display("FAIL pop2_latency got %0d want 4", r_lat); end
        tests_run++; if (sp_o !== 16'hFFFF) begin tests_failed++; $display("FAIL pp_final_sp got %h want FFFF", sp_o); end
    endtask

    task automatic test_underflow();
        do_op(2'b01, 16'h0000, 1);
        $display("[TB] POP empty: lat=%0d err=%b mem=%0d sp=%h", r_lat, r_err, r_saw_mem, sp_o);
        tests_run++; if (r_lat !== 1 || r_err !== 1'b1) begin tests_failed++; $display("FAIL underflow_rsp got lat=%0d err=%b want 1/1", r_lat, r_err); end
        tests_run++; if (r_saw_mem) begin tests_failed++; $display("FAIL underflow_mem got mem_req want none"); end
        tests_run++; if (err_underflow_o !== 1'b1 || err_overflow_o !== 1'b0) begin
            tests_failed++; $display("FAIL underflow_sticky got udf=%b ovf=%b want 1/0", err_underflow_o, err_overflow_o); end
        tests_run++; if (sp_o !== 16'hFFFF) begin tests_failed++; $display("FAIL underflow_sp got %h want FFFF", sp_o); end
    endtask

    task automatic test_overflow();
        do_op(2'b11, 16'hFF00, 1);
        $display("[TB] LOAD_SP FF00: lat=%0d rsp=%h err=%b sp=%h", r_lat, r_data, r_err, sp_o);
        tests_run++; if (r_lat !== 1 || r_data !== 16'hFF00 || r_err !== 1'b0 || r_saw_mem) begin
            tests_failed++; $display("FAIL loadsp_rsp got lat=%0d data=%h err=%b mem=%0d want 1/FF00/0/0", r_lat, r_data, r_err, r_saw_mem); end
        tests_run++; if (sp_o !== 16'hFF00) begin tests_failed++; $display("FAIL loadsp_sp got %h want FF00", sp_o); end
        do_op(2'b00, 16'h0001, 1);
        $display("[TB] PUSH at limit: lat=%0d err=%b mem=%0d sp=%h", r_lat, r_err, r_saw_mem, sp_o);
        tests_run++; if (r_lat !== 1 || r_err !== 1'b1 || r_saw_mem) begin
            tests_failed++; $display("FAIL overflow_rsp got lat=%0d err=%b mem=%0d want 1/1/0", r_lat, r_err, r_saw_mem); end
        tests_run++; if (err_overflow_o !== 1'b1 || err_underflow_o !== 1'b1) begin
            tests_failed++; $display("FAIL overflow_sticky got ovf=%b udf=%b want 1/1", err_overflow_o, err_underflow_o); end
        tests_run++; if (sp_o !== 16'hFF00) begin tests_failed++; $display("FAIL overflow_sp got %h want FF00", sp_o); end
        // One above the limit is still a legal push.
        do_op(2'b11, 16'hFF01, 1);
        do_op(2'b00, 16'h0002, 1);
        $display("[TB] PUSH at FF01: err=%b addr=%h sp=%h", r_err, r_addr, sp_o);
        tests_run++; if (r_err !== 1'b0 || r_addr !== 16'hFF01 || sp_o !== 16'hFF00) begin
            tests_failed++; $display("FAIL limit_plus1 got err=%b addr=%h sp=%h want 0/FF01/FF00", r_err, r_addr, sp_o); end
    endtask

    task automatic test_peek_slow();
        apply_reset();
        do_op(2'b00, 16'hBEEF, 1);
        do_op(2'b10, 16'h0000, 5);
        $display("[TB] PEEK ack5: lat=%0d addr=%h we=%b rsp=%h sp=%h stable=%0d busy=%0d", r_lat, r_addr, r_we, r_data, sp_o, r_stable, r_ready_low);
        tests_run++; if (r_data !== 16'hBEEF || r_err !== 1'b0) begin tests_failed++; $display("FAIL peek_data got %h/%b want BEEF/0", r_data, r_err); end
        tests_run++; if (r_addr !== 16'hFFFF || r_we !== 1'b0) begin tests_failed++; $display("FAIL peek_addr got %h/%b want FFFF/0", r_addr, r_we); end
        tests_run++; if (sp_o !== 16'hFFFE) begin tests_failed++; $display("FAIL peek_sp got %h want FFFE", sp_o); end
        tests_run++; if (r_lat !== 6) begin tests_failed++; $display("FAIL peek_latency got %0d want 6", r_lat); end
        tests_run++; if (!r_stable || !r_ready_low) begin tests_failed++; $display("FAIL peek_hold got stable=%0d busy=%0d want 1/1", r_stable, r_ready_low); end
    endtask

    task automatic test_reset_mid_access();
        bit saw_rsp;
        apply_reset();
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = 2'b00; req_data_i = 16'h7777;
        @(negedge clk);
        req_valid_i = 1'b0;
        tests_run++; if (mem_req_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_req got %b want 1", mem_req_o); end
        #1 reset = 1'b1;
        #1;
        $display("[TB] reset mid-access: sp=%h mem_req=%b rsp_valid=%b", sp_o, mem_req_o, rsp_valid_o);
        tests_run++; if (sp_o !== 16'hFFFF || mem_req_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_state got sp=%h req=%b valid=%b want FFFF/0/0", sp_o, mem_req_o, rsp_valid_o); end
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        reset = 1'b0;
        saw_rsp = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid_o) saw_rsp = 1; end
        tests_run++; if (saw_rsp) begin tests_failed++; $display("FAIL midrst_norsp got rsp_valid want none"); end
        do_op(2'b00, 16'h0042, 2);
        $display("[TB] PUSH after reset: lat=%0d addr=%h rsp=%h sp=%h", r_lat, r_addr, r_data, sp_o);
        tests_run++; if (r_lat !== 3 || r_addr !== 16'hFFFF || r_wdata !== 16'h0042 || sp_o !== 16'hFFFE || r_data !== 16'hFFFE) begin
            tests_failed++; $display("FAIL midrst_push got lat=%0d addr=%h wdata=%h sp=%h rsp=%h want 3/FFFF/0042/FFFE/FFFE", r_lat, r_addr, r_wdata, sp_o, r_data); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        // Request held continuously: each op must take exactly 2 cycles of spacing.
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = 2'b11; req_data_i = 16'h8000;
        @(negedge clk);
        tests_run++; if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || sp_o !== 16'h8000) begin
            tests_failed++; $display("FAIL b2b_first got valid=%b ready=%b sp=%h want 1/0/8000", rsp_valid_o, req_ready_o, sp_o); end
        req_data_i = 16'h4000;
        @(negedge clk);
        tests_run++; if (req_ready_o !== 1'b1 || sp_o !== 16'h8000) begin
            tests_failed++; $display("FAIL b2b_idle got ready=%b sp=%h want 1/8000", req_ready_o, sp_o); end
        @(negedge clk);
        req_valid_i = 1'b0;
        $display("[TB] back-to-back LOAD_SP: valid=%b rsp=%h sp=%h", rsp_valid_o, rsp_data_o, sp_o);
        tests_run++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 16'h4000 || sp_o !== 16'h4000) begin
            tests_failed++; $display("FAIL b2b_second got valid=%b data=%h sp=%h want 1/4000/4000", rsp_valid_o, rsp_data_o, sp_o); end
        @(negedge clk);
        // Stray ack while idle must not move SP.
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        tests_run++; if (sp_o !== 16'h4000 || rsp_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL stray_ack got sp=%h valid=%b want 4000/0", sp_o, rsp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_push_pop();
        test_underflow();
        test_overflow();
        test_peek_slow();
        test_reset_mid_access();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
